router_ctrl: RTL and testbench

Packet-sequencing controller for the 1x3 router. It decodes the 2-bit destination address in each header byte and steers writes into one of the three output FIFOs. It drives the FIFOs' header tag (`lfd_state`) and stalls the source while a FIFO is full. It also watches each output port and soft-resets any FIFO whose data is not read within a timeout.

---
 rtl/router_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_router_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_ctrl.sv
// Packet-sequencing controller for the 1x3 router: header decode, FIFO write steering and full stalls.
// Optional per-port read-timeout soft reset is built when ROUTER_SOFT_RESET_EN is defined.
module router_ctrl #(
    parameter int TIMEOUT_CYCLES = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic [2:0] write_enb,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset,
    output logic       fifo_full_sel,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     state_r;
    state_t     next_s;
    state_t     normal_s;
    logic [1:0] addr_r;
    logic [3:0] empty_pad_s;
    logic [3:0] full_pad_s;
    logic       hdr_ok_s;
    logic       wr_s;
    logic       override_s;

    // Padding to four entries keeps the invalid address 3 in range; it reads as not empty / not full.
    assign empty_pad_s   = {1'b0, fifo_empty};
    assign full_pad_s    = {1'b0, fifo_full};
    assign hdr_ok_s      = pkt_valid && (data_in != 2'd3);
    assign fifo_full_sel = full_pad_s[addr_r];
    assign vld_out       = ~fifo_empty;

`ifdef ROUTER_SOFT_RESET_EN
    localparam logic [4:0] CNT_LIMIT = 5'(TIMEOUT_CYCLES - 1);

    logic [4:0] cnt_r [3];
    logic [2:0] soft_reset_r;
    logic [3:0] sr_pad_s;

    // Per-port stall timers; a read or an idle port clears the count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= 5'd0;
            end
            soft_reset_r <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (vld_out[i] && !read_enb[i]) begin
                    if (cnt_r[i] == CNT_LIMIT) begin
                        soft_reset_r[i] <= 1'b1;
                        cnt_r[i]        <= 5'd0;
                    end else begin
                        soft_reset_r[i] <= 1'b0;
                        cnt_r[i]        <= cnt_r[i] + 5'd1;
                    end
                end else begin
                    soft_reset_r[i] <= 1'b0;
                    cnt_r[i]        <= 5'd0;
                end
            end
        end
    end

    assign soft_reset = soft_reset_r;
    assign sr_pad_s   = {1'b0, soft_reset_r};
    assign override_s = sr_pad_s[addr_r] && (state_r != DECODE_ADDRESS);
`else
    logic unused_s;

    assign unused_s   = ^{read_enb, 5'(TIMEOUT_CYCLES)};
    assign soft_reset = 3'b000;
    assign override_s = 1'b0;
`endif

    // Destination address capture from an accepted header.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_r <= 2'd0;
        end else if ((state_r == DECODE_ADDRESS) && hdr_ok_s) begin
            addr_r <= data_in;
        end else begin
            addr_r <= addr_r;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= DECODE_ADDRESS;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; a timeout on the active port abandons the packet.
    always_comb begin
        normal_s = state_r;
        case (state_r)
            DECODE_ADDRESS: begin
                if (hdr_ok_s && empty_pad_s[data_in]) begin
                    normal_s = LOAD_FIRST_DATA;
                end else if (hdr_ok_s) begin
                    normal_s = WAIT_TILL_EMPTY;
                end else begin
                    normal_s = DECODE_ADDRESS;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_pad_s[addr_r]) begin
                    normal_s = LOAD_FIRST_DATA;
                end else begin
                    normal_s = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: normal_s = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full_sel) begin
                    normal_s = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    normal_s = LOAD_PARITY;
                end else begin
                    normal_s = LOAD_DATA;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full_sel) begin
                    normal_s = LOAD_AFTER_FULL;
                end else begin
                    normal_s = FIFO_FULL_STATE;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    normal_s = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    normal_s = LOAD_PARITY;
                end else begin
                    normal_s = LOAD_DATA;
                end
            end
            LOAD_PARITY: normal_s = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                if (fifo_full_sel) begin
                    normal_s = FIFO_FULL_STATE;
                end else begin
                    normal_s = DECODE_ADDRESS;
                end
            end
            default: normal_s = DECODE_ADDRESS;
        endcase
        next_s = override_s ? DECODE_ADDRESS : normal_s;
    end

    // Moore state decodes and one-hot write steering.
    always_comb begin
        detect_add  = (state_r == DECODE_ADDRESS);
        lfd_state   = (state_r == LOAD_FIRST_DATA);
        ld_state    = (state_r == LOAD_DATA);
        laf_state   = (state_r == LOAD_AFTER_FULL);
        full_state  = (state_r == FIFO_FULL_STATE);
        rst_int_reg = (state_r == CHECK_PARITY_ERROR);
        busy        = !((state_r == DECODE_ADDRESS) || (state_r == LOAD_DATA));
        wr_s        = lfd_state || ld_state || laf_state || (state_r == LOAD_PARITY);
        write_enb   = 3'b000;
        case (addr_r)
            2'd0:    write_enb = {2'b00, wr_s};
            2'd1:    write_enb = {1'b0, wr_s, 1'b0};
            2'd2:    write_enb = {wr_s, 2'b00};
            default: write_enb = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl: vector table for the packet FSM plus sequences for reset and timeouts.
module tb_router_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] write_enb;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
    logic       fifo_full_sel;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [5:0] S_D   = 6'b100000;
    localparam logic [5:0] S_LFD = 6'b010000;
    localparam logic [5:0] S_LD  = 6'b001000;
    localparam logic [5:0] S_LAF = 6'b000100;
    localparam logic [5:0] S_FF  = 6'b000010;
    localparam logic [5:0] S_CPE = 6'b000001;
    localparam logic [5:0] S_NON = 6'b000000;

    typedef struct {
        logic       pv;
        logic [1:0] din;
        logic [2:0] full;
        logic [2:0] empty;
        logic       pd;
        logic       lpv;
        logic [5:0] dec;
        logic       busy;
        logic [2:0] we;
        logic       we_care;
        logic       ffs;
    } vec_t;

    vec_t vecs[$];

    router_ctrl #(.TIMEOUT_CYCLES(30)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .write_enb(write_enb), .vld_out(vld_out), .soft_reset(soft_reset),
        .fifo_full_sel(fifo_full_sel), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic pv, input logic [1:0] din, input logic [2:0] full,
                                 input logic [2:0] empty, input logic pd, input logic lpv,
                                 input logic [5:0] dec, input logic bsy, input logic [2:0] we,
                                 input logic we_care, input logic ffs);
        vec_t v;
        v.pv = pv; v.din = din; v.full = full; v.empty = empty; v.pd = pd; v.lpv = lpv;
        v.dec = dec; v.busy = bsy; v.we = we; v.we_care = we_care; v.ffs = ffs;
        return v;
    endfunction

    function automatic logic [5:0] dec_now();
        return {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg};
    endfunction

    task automatic idle_inputs();
        pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 3'b000; fifo_empty = 3'b111;
        read_enb = 3'b111; parity_done = 1'b0; low_pkt_valid = 1'b0;
    endtask

    initial begin
        logic [2:0]  we_mask;
        logic [15:0] act_v, exp_v;
        logic        seen;

        // Packet to port 1 with three payload bytes.
        vecs.push_back(mkv(1'b1, 2'd1, 3'b000, 3'b111, 1'b0, 1'b0, S_D,   1'b0, 3'b000, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_LFD, 1'b1, 3'b010, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_LD,  1'b0, 3'b010, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_LD,  1'b0, 3'b010, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_LD,  1'b0, 3'b010, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_NON, 1'b1, 3'b010, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_CPE, 1'b1, 3'b000, 1'b1, 1'b0));
        // Invalid address 3 is ignored.
        vecs.push_back(mkv(1'b1, 2'd3, 3'b000, 3'b111, 1'b0, 1'b0, S_D,   1'b0, 3'b000, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b1, 2'd3, 3'b000, 3'b111, 1'b0, 1'b0, S_D,   1'b0, 3'b000, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_D,   1'b0, 3'b000, 1'b1, 1'b0));
        // Port 2 busy: wait until it drains.
        vecs.push_back(mkv(1'b1, 2'd2, 3'b000, 3'b011, 1'b0, 1'b0, S_D,   1'b0, 3'b000, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b011, 1'b0, 1'b0, S_NON, 1'b1, 3'b000, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_NON, 1'b1, 3'b000, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_LFD, 1'b1, 3'b100, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_LD,  1'b0, 3'b100, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_NON, 1'b1, 3'b100, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_CPE, 1'b1, 3'b000, 1'b1, 1'b0));
        // Port 0 goes full for four cycles mid-payload.
        vecs.push_back(mkv(1'b1, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_D,   1'b0, 3'b000, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_LFD, 1'b1, 3'b001, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_LD,  1'b0, 3'b001, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b001, 3'b111, 1'b0, 1'b0, S_LD,  1'b0, 3'b001, 1'b0, 1'b1));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b001, 3'b111, 1'b0, 1'b0, S_FF,  1'b1, 3'b000, 1'b1, 1'b1));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b001, 3'b111, 1'b0, 1'b0, S_FF,  1'b1, 3'b000, 1'b1, 1'b1));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b001, 3'b111, 1'b0, 1'b0, S_FF,  1'b1, 3'b000, 1'b1, 1'b1));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_FF,  1'b1, 3'b000, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_LAF, 1'b1, 3'b001, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_LD,  1'b0, 3'b001, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_NON, 1'b1, 3'b001, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_CPE, 1'b1, 3'b000, 1'b1, 1'b0));
        // LOAD_AFTER_FULL exits via low_pkt_valid and parity_done; CPE re-enters FULL.
        vecs.push_back(mkv(1'b1, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_D,   1'b0, 3'b000, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_LFD, 1'b1, 3'b001, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b001, 3'b111, 1'b0, 1'b0, S_LD,  1'b0, 3'b001, 1'b0, 1'b1));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_FF,  1'b1, 3'b000, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b1, 2'd0, 3'b000, 3'b111, 1'b0, 1'b1, S_LAF, 1'b1, 3'b001, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b001, 3'b111, 1'b0, 1'b0, S_NON, 1'b1, 3'b001, 1'b1, 1'b1));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b001, 3'b111, 1'b0, 1'b0, S_CPE, 1'b1, 3'b000, 1'b1, 1'b1));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_FF,  1'b1, 3'b000, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b1, 1'b0, S_LAF, 1'b1, 3'b001, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b0, 2'd0, 3'b000, 3'b111, 1'b0, 1'b0, S_D,   1'b0, 3'b000, 1'b1, 1'b0));

        // Reset values.
        idle_inputs();
        fifo_empty = 3'b010;
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check("reset_dec", 32'(dec_now()), 32'(S_D));
        check("reset_busy_we_sr", 32'({busy, write_enb, soft_reset}), 32'd0);
        check("reset_vld_out", 32'(vld_out), 32'(3'b101));
        fifo_empty = 3'b111;
        resetn = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clock);
            pkt_valid = vecs[k].pv; data_in = vecs[k].din; fifo_full = vecs[k].full;
            fifo_empty = vecs[k].empty; parity_done = vecs[k].pd; low_pkt_valid = vecs[k].lpv;
            read_enb = 3'b111;
            #1;
            we_mask = vecs[k].we_care ? 3'b111 : 3'b000;
            act_v = {dec_now(), busy, write_enb & we_mask, vld_out, fifo_full_sel, soft_reset[1:0]};
            exp_v = {vecs[k].dec, vecs[k].busy, vecs[k].we & we_mask, ~vecs[k].empty, vecs[k].ffs, 2'b00};
            check($sformatf("vec%0d", k), 32'(act_v), 32'(exp_v));
        end

        // Reset asserted mid-packet.
        @(negedge clock);
        idle_inputs();
        pkt_valid = 1'b1; data_in = 2'd1;
        @(negedge clock);
        @(negedge clock);
        #1;
        check("midpkt_in_ld", 32'(dec_now()), 32'(S_LD));
        resetn = 1'b0;
        #1;
        check("midpkt_reset_dec", 32'(dec_now()), 32'(S_D));
        check("midpkt_reset_we", 32'(write_enb), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        pkt_valid = 1'b0;
        @(negedge clock);
        #1;
        check("midpkt_after_dec", 32'({dec_now(), write_enb}), 32'({S_D, 3'b000}));

`ifdef ROUTER_SOFT_RESET_EN
        // Port 2 stalled: pulse at edge 30 only.
        fifo_empty = 3'b011; read_enb = 3'b000;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            check($sformatf("tmo_a%0d", c), 32'(soft_reset), (c == 30) ? 32'd4 : 32'd0);
        end
        // Read in the would-fire cycle suppresses the pulse.
        fifo_empty = 3'b111;
        @(negedge clock);
        fifo_empty = 3'b011;
        repeat (29) @(negedge clock);
        read_enb = 3'b100;
        @(negedge clock);
        check("tmo_read_suppress", 32'(soft_reset), 32'd0);
        read_enb = 3'b000;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clock);
            check($sformatf("tmo_b%0d", c), 32'(soft_reset), (c == 30) ? 32'd4 : 32'd0);
        end
        // Timeout on the active port while in LOAD_DATA forces DECODE_ADDRESS.
        idle_inputs();
        @(negedge clock);
        @(negedge clock);
        pkt_valid = 1'b1; data_in = 2'd1;
        @(negedge clock);
        fifo_empty = 3'b101; read_enb = 3'b000;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clock);
            #1;
            if (soft_reset[1]) begin
                seen = 1'b1;
                check("ovr_in_ld", 32'(dec_now()), 32'(S_LD));
                @(negedge clock);
                #1;
                check("ovr_to_decode", 32'(dec_now()), 32'(S_D));
            end
        end
        check("ovr_pulse_seen", 32'(seen), 32'd1);
        idle_inputs();
`else
        // Without the timers, soft_reset never fires.
        fifo_empty = 3'b000; read_enb = 3'b000;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            check($sformatf("no_sr%0d", c), 32'(soft_reset), 32'd0);
        end
        idle_inputs();
`endif

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
